factorizer_serial: RTL and testbench

FACTORIZER_SERIAL -- requirements
Module: factorizer_serial

---
 rtl/factorizer_pkg.sv | 13 +
 rtl/mod_step.sv | 22 ++
 rtl/factorizer_serial.sv | 126 ++++++++++++
 tb/tb_factorizer_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/factorizer_pkg.sv
// Shared definitions for the serial factorizer: FSM state encoding and parameter defaults.
package factorizer_pkg;

  localparam int unsigned FACT_WIDTH_DEF   = 7;
  localparam int unsigned FACT_MAX_DIV_DEF = 9;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mod_step.sv
// One MSB-first residue step for a fixed divisor: r' = (2r+b >= DIV) ? 2r+b-DIV : 2r+b.
module mod_step #(
  parameter int unsigned DIV = 3,
  parameter int unsigned RW  = 4
) (
  input  logic [RW-1:0] residue,
  input  logic          bit_in,
  output logic [RW-1:0] residue_next
);

  logic [RW:0] t_c;

  // Residue stays below DIV, so a single conditional subtract keeps it reduced.
  always_comb begin
    t_c          = {residue, bit_in};
    residue_next = RW'(t_c);
    if (t_c >= (RW+1)'(DIV)) begin
      residue_next = RW'(t_c - (RW+1)'(DIV));
    end
  end

endmodule

// File: rtl/factorizer_serial.sv
// Bit-serial divisibility tester: reports which of 2..MAX_DIV divide the operand.
module factorizer_serial
  import factorizer_pkg::*;
#(
  parameter int unsigned WIDTH   = FACT_WIDTH_DEF,
  parameter int unsigned MAX_DIV = FACT_MAX_DIV_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           number,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAX_DIV-2:0]         factors,
  output logic [$clog2(MAX_DIV)-1:0] factor_count
);

  localparam int unsigned RW   = $clog2(MAX_DIV);
  localparam int unsigned NDIV = MAX_DIV - 1;
  localparam int unsigned CW   = $clog2(WIDTH);

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         shreg_q, shreg_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NDIV-1:0][RW-1:0]  res_q, res_d, res_nxt_c;
  logic [NDIV-1:0]          factors_q, factors_d;
  logic [RW-1:0]            fcount_q, fcount_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [NDIV-1:0]          zero_c;
  logic [RW-1:0]            pop_c;

  // One residue stepper per divisor, all fed the current operand MSB.
  for (genvar d = 2; d <= MAX_DIV; d++) begin : g_div
    mod_step #(
      .DIV (d),
      .RW  (RW)
    ) u_step (
      .residue      (res_q[d-2]),
      .bit_in       (shreg_q[WIDTH-1]),
      .residue_next (res_nxt_c[d-2])
    );
  end

  // Divisibility flags and their population count from the post-step residues.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < NDIV; i++) begin
      zero_c[i] = (res_nxt_c[i] == '0);
      pop_c     = pop_c + RW'(zero_c[i]);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    factors_d = factors_q;
    fcount_d  = fcount_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = number;
          res_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        shreg_d = shreg_q << 1;
        res_d   = res_nxt_c;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d     = '0;
          factors_d = zero_c;
          fcount_d  = pop_c;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      factors_q   <= '0;
      fcount_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      factors_q   <= factors_d;
      fcount_q    <= fcount_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign factors      = factors_q;
  assign factor_count = fcount_q;

endmodule

// File: tb/tb_factorizer_serial.sv
// Self-checking bench for factorizer_serial at default and widened parameters.
module tb_factorizer_serial;

  localparam int unsigned W   = 7;
  localparam int unsigned MD  = 9;
  localparam int unsigned WB  = 12;
  localparam int unsigned MDB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  number;
  logic [MD-2:0] factors;
  logic [3:0]    factor_count;

  logic           in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [WB-1:0]  number_b;
  logic [MDB-2:0] factors_b;
  logic [3:0]     factor_count_b;

  factorizer_serial u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .number       (number),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .factors      (factors),
    .factor_count (factor_count)
  );

  factorizer_serial #(.WIDTH(WB), .MAX_DIV(MDB)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid_b),
    .in_ready     (in_ready_b),
    .number       (number_b),
    .out_valid    (out_valid_b),
    .out_ready    (out_ready_b),
    .factors      (factors_b),
    .factor_count (factor_count_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: divisor d contributes bit d-2 when it divides n evenly.
  function automatic logic [31:0] model_factors(input int unsigned n, input int unsigned md);
    logic [31:0] r;
    r = '0;
    for (int unsigned d = 2; d <= md; d++) begin
      if (n % d == 0) r[d-2] = 1'b1;
    end
    return r;
  endfunction

  // One transaction on the default instance, with optional DONE stall.
  task automatic run_a(input logic [W-1:0] n, input int unsigned stall,
                       input bit chk_tput, input string tag);
    int unsigned t, lat, acc;
    logic [31:0] ef;
    ef = model_factors(n, MD);
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    check({tag, "/rdy"}, 32'(in_ready), 32'd1);
    number   = n;
    in_valid = 1'b1;
    tick();
    acc = cyc;
    if (chk_tput) check({tag, "/tput"}, acc - last_acc, W + 2);
    last_acc  = acc;
    out_ready = (stall == 0);
    in_valid  = 1'($urandom_range(0, 1));
    number    = W'($urandom);
    lat = 0;
    do begin tick(); lat++; end while (!out_valid && lat < W + 4);
    check({tag, "/lat"}, lat, W);
    check({tag, "/fac"}, 32'(factors), ef);
    check({tag, "/cnt"}, 32'(factor_count), $countones(ef));
    for (int unsigned s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      number   = W'($urandom);
      tick();
      check({tag, "/bp_ov"}, 32'(out_valid), 32'd1);
      check({tag, "/bp_ir"}, 32'(in_ready), 32'd0);
      check({tag, "/bp_fac"}, 32'(factors), ef);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "/ret_ov"}, 32'(out_valid), 32'd0);
    check({tag, "/ret_ir"}, 32'(in_ready), 32'd1);
    check({tag, "/hold"}, 32'(factors), ef);
  endtask

  // One transaction on the widened instance.
  task automatic run_b(input logic [WB-1:0] n, input string tag);
    int unsigned t, lat;
    logic [31:0] ef;
    ef = model_factors(n, MDB);
    t = 0;
    while (!in_ready_b && t < 50) begin tick(); t++; end
    number_b   = n;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    number_b   = WB'($urandom);
    lat = 0;
    do begin tick(); lat++; end while (!out_valid_b && lat < WB + 4);
    check({tag, "/lat"}, lat, WB);
    check({tag, "/fac"}, 32'(factors_b), ef);
    check({tag, "/cnt"}, 32'(factor_count_b), $countones(ef));
    tick();
  endtask

  initial begin
    bit seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    number      = '0;
    out_ready   = 1'b1;
    in_valid_b  = 1'b0;
    number_b    = '0;
    out_ready_b = 1'b1;
    repeat (3) tick();
    check("rst/ir", 32'(in_ready), 32'd1);
    check("rst/ov", 32'(out_valid), 32'd0);
    check("rst/fac", 32'(factors), 32'd0);
    check("rst/cnt", 32'(factor_count), 32'd0);
    reset = 1'b0;
    tick();

    run_a(7'd72, 0, 1'b0, "n72");
    check("n72/const", 32'(factors), 32'hD7);
    check("n72/cconst", 32'(factor_count), 32'd6);
    run_a(7'd0, 0, 1'b0, "n0");
    check("n0/const", 32'(factors), 32'hFF);
    check("n0/cconst", 32'(factor_count), 32'd8);
    run_a(7'd97, 0, 1'b0, "n97");
    check("n97/const", 32'(factors), 32'h00);
    run_a(7'd35, 0, 1'b0, "n35");
    check("n35/const", 32'(factors), 32'h28);
    check("n35/cconst", 32'(factor_count), 32'd2);
    run_a(7'd1, 0, 1'b0, "n1");
    check("n1/const", 32'(factors), 32'h00);
    run_a(7'd60, 5, 1'b0, "bp");

    // Abort an operation with reset on the third RUN cycle.
    number   = 7'd72;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort/ov", 32'(out_valid), 32'd0);
    check("abort/ir", 32'(in_ready), 32'd1);
    check("abort/fac", 32'(factors), 32'd0);
    seen = 1'b0;
    repeat (W + 3) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort/noresult", 32'(seen), 32'd0);
    run_a(7'd72, 0, 1'b0, "post_abort");
    check("post_abort/const", 32'(factors), 32'hD7);

    for (int i = 0; i < 30; i++) begin
      run_a(W'($urandom), $urandom_range(0, 3), 1'b0, "rand");
    end

    for (int unsigned n = 0; n < (1 << W); n++) begin
      run_a(W'(n), 0, (n != 0), "exh");
    end

    run_b(12'd3600, "b3600");
    check("b3600/const", 32'(factors_b), 32'h65DF);
    check("b3600/cconst", 32'(factor_count_b), 32'd11);
    for (int i = 0; i < 20; i++) begin
      run_b(WB'($urandom), "brand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
